sdf_stage_ctrl: RTL and testbench

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

---
 rtl/fft_pkg.sv | 25 ++
 rtl/sdf_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the 128-point SDF FFT pipeline.
// Stage controllers and the twiddle ROM both import this package.
package fft_pkg;

    localparam int N_FFT  = 128;
    localparam int IDX_W  = 7;
    localparam int TW_AW  = 6;
    localparam int DATA_W = 24;
    localparam int ONE    = 256;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PASS  = 2'd1,
        ST_BFLY  = 2'd2,
        ST_DRAIN = 2'd3
    } stage_mode_e;

    // The product is formed at IDX_W bits and only the low TW_AW bits are kept;
    // for every legal delay/stride pair the result is below 64.
    function automatic logic [TW_AW-1:0] tw_index(input logic [IDX_W-1:0] k,
                                                  input logic [IDX_W-1:0] stride);
        return TW_AW'(k * stride);
    endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one single-path delay-feedback FFT stage: tracks the sample
// index, selects fill/pass/butterfly/drain mode and drives the twiddle index.
//
//   state | meaning
//   FILL  | first DELAY samples of a stream load the delay line, no output
//   PASS  | p < DELAY: delay-line output is rotated by twiddle[p*STRIDE]
//   BFLY  | p >= DELAY: butterfly of delay-line and input, no rotation
//   DRAIN | DELAY cycles flushing the delay line after the frame's last sample
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int DELAY  = 4,
    parameter int STRIDE = 64 / DELAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    output logic [1:0]       state,
    output logic [TW_AW-1:0] tw_addr,
    output logic             tw_en,
    output logic             out_valid,
    output logic             frame_done,
    output logic             err
);

    localparam logic [IDX_W-1:0] P_MASK  = IDX_W'(2 * DELAY - 1);
    localparam logic [IDX_W-1:0] D_VAL   = IDX_W'(DELAY);
    localparam logic [IDX_W-1:0] D_LAST  = IDX_W'(DELAY - 1);
    localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] STRIDE7 = IDX_W'(STRIDE);

    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] j_q, j_d;
    logic             fill_q, fill_d;
    logic             drain_q, drain_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] p;
    logic             accept;
    stage_mode_e      mode;

    assign p      = i_q & P_MASK;
    assign accept = in_valid & ~drain_q;

    // State register: mode flags plus sample and drain counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q          <= '0;
            j_q          <= '0;
            fill_q       <= 1'b1;
            drain_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            i_q          <= i_d;
            j_q          <= j_d;
            fill_q       <= fill_d;
            drain_q      <= drain_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic. An idle cycle outside drain leaves every counter alone.
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        fill_d  = fill_q;
        drain_d = drain_q;

        if (drain_q) begin
            if (j_q == D_LAST) begin
                drain_d = 1'b0;
                fill_d  = 1'b1;
                i_d     = '0;
                j_d     = '0;
            end else begin
                j_d = j_q + 1'b1;
            end
        end else if (accept) begin
            i_d = i_q + 1'b1;
            if (fill_q && (i_q == D_LAST)) begin
                fill_d = 1'b0;
            end
            // i wraps to 0 here; the drain hands back to FILL with i already 0.
            if (in_last && (i_q == I_LAST)) begin
                drain_d = 1'b1;
                j_d     = '0;
            end
        end
    end

    // Registered status: output strobe, frame pulse and sticky protocol error.
    always_comb begin
        out_valid_d  = drain_q | (accept & ~fill_q);
        frame_done_d = accept & (i_q == I_LAST);
        err_d        = err_q
                     | (in_valid & drain_q)
                     | (accept & in_last & (i_q != I_LAST));
    end

    // Output logic: mode decode and twiddle selection from registered counters.
    always_comb begin
        mode    = ST_BFLY;
        tw_en   = 1'b0;
        tw_addr = '0;

        if (drain_q) begin
            mode    = ST_DRAIN;
            tw_en   = 1'b1;
            tw_addr = tw_index(j_q, STRIDE7);
        end else if (fill_q) begin
            mode = ST_FILL;
        end else if (p < D_VAL) begin
            mode    = ST_PASS;
            tw_en   = 1'b1;
            tw_addr = tw_index(p, STRIDE7);
        end
    end

    assign state      = mode;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl with DELAY=4, STRIDE=16.
module tb_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [1:0] state;
    logic [5:0] tw_addr;
    logic       tw_en;
    logic       out_valid;
    logic       frame_done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    sdf_stage_ctrl #(.DELAY(4), .STRIDE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .state      (state),
        .tw_addr    (tw_addr),
        .tw_en      (tw_en),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1);
    end

    // Inputs change just after the falling edge; combinational outputs are read 1ns later.
    task automatic drive(input logic v, input logic l);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        #1;
    endtask

    // Advance past the rising edge so registered outputs can be read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic feed(input int n);
        repeat (n) begin
            drive(1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
        n_checks++; if (tw_addr !== 6'd0)    begin n_fail++; $display("FAIL reset_tw_addr got %0d want 0", tw_addr); end
        n_checks++; if (tw_en !== 1'b0)      begin n_fail++; $display("FAIL reset_tw_en got %b want 0", tw_en); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_pass();
        int es [12];
        int et [12];
        es = '{0, 0, 0, 0, 2, 2, 2, 2, 1, 1, 1, 1};
        et = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 32, 48};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0);
            n_checks++; if (state !== 2'(es[k]))   begin n_fail++; $display("FAIL seq_state k=%0d got %0d want %0d", k, state, es[k]); end
            n_checks++; if (tw_addr !== 6'(et[k])) begin n_fail++; $display("FAIL seq_tw_addr k=%0d got %0d want %0d", k, tw_addr, et[k]); end
            n_checks++; if (tw_en !== (es[k] == 1)) begin n_fail++; $display("FAIL seq_tw_en k=%0d got %b want %b", k, tw_en, es[k] == 1); end
            tick();
            n_checks++; if (out_valid !== (k >= 4)) begin n_fail++; $display("FAIL seq_out_valid k=%0d got %b want %b", k, out_valid, k >= 4); end
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_stall();
        int vv [10];
        int es [10];
        int et [10];
        int eo [10];
        vv = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
        es = '{2, 2, 2, 2, 2, 1, 1, 1, 1, 1};
        et = '{0, 0, 0, 0, 0, 0, 16, 16, 16, 32};
        eo = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
        do_reset();
        feed(6);
        for (int k = 0; k < 10; k++) begin
            drive(vv[k] != 0, 1'b0);
            n_checks++; if (state !== 2'(es[k]))   begin n_fail++; $display("FAIL stall_state k=%0d got %0d want %0d", k, state, es[k]); end
            n_checks++; if (tw_addr !== 6'(et[k])) begin n_fail++; $display("FAIL stall_tw_addr k=%0d got %0d want %0d", k, tw_addr, et[k]); end
            n_checks++; if (tw_en !== (es[k] == 1)) begin n_fail++; $display("FAIL stall_tw_en k=%0d got %b want %b", k, tw_en, es[k] == 1); end
            tick();
            n_checks++; if (out_valid !== (eo[k] != 0)) begin n_fail++; $display("FAIL stall_out_valid k=%0d got %b want %0d", k, out_valid, eo[k]); end
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 128; k++) begin
            drive(1'b1, 1'b0);
            if (k == 127) begin
                n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL wrap_last_state got %0d want 2", state); end
            end
            tick();
            n_checks++; if (frame_done !== (k == 127)) begin n_fail++; $display("FAIL wrap_frame_done k=%0d got %b want %b", k, frame_done, k == 127); end
        end
        drive(1'b1, 1'b0);
        n_checks++; if (state !== 2'd1)   begin n_fail++; $display("FAIL wrap_next_state got %0d want 1", state); end
        n_checks++; if (tw_addr !== 6'd0) begin n_fail++; $display("FAIL wrap_next_tw_addr got %0d want 0", tw_addr); end
        n_checks++; if (tw_en !== 1'b1)   begin n_fail++; $display("FAIL wrap_next_tw_en got %b want 1", tw_en); end
        tick();
        n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL wrap_next_out_valid got %b want 1", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_width got %b want 0", frame_done); end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_drain();
        do_reset();
        feed(127);
        drive(1'b1, 1'b1);
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL drain_last_state got %0d want 2", state); end
        tick();
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL drain_frame_done got %b want 1", frame_done); end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0);
            n_checks++; if (state !== 2'd3)          begin n_fail++; $display("FAIL drain_state j=%0d got %0d want 3", j, state); end
            n_checks++; if (tw_addr !== 6'(j * 16))  begin n_fail++; $display("FAIL drain_tw_addr j=%0d got %0d want %0d", j, tw_addr, j * 16); end
            n_checks++; if (tw_en !== 1'b1)          begin n_fail++; $display("FAIL drain_tw_en j=%0d got %b want 1", j, tw_en); end
            tick();
            n_checks++; if (out_valid !== 1'b1)      begin n_fail++; $display("FAIL drain_out_valid j=%0d got %b want 1", j, out_valid); end
        end
        drive(1'b0, 1'b0);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL drain_exit_state got %0d want 0", state); end
        n_checks++; if (tw_en !== 1'b0) begin n_fail++; $display("FAIL drain_exit_tw_en got %b want 0", tw_en); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_exit_out_valid got %b want 0", out_valid); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL drain_err got %b want 0", err); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0);
            n_checks++; if (state !== ((k < 4) ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL refill_state k=%0d got %0d want %0d", k, state, (k < 4) ? 0 : 2); end
            tick();
            n_checks++; if (out_valid !== (k == 4)) begin n_fail++; $display("FAIL refill_out_valid k=%0d got %b want %b", k, out_valid, k == 4); end
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_err_last();
        do_reset();
        feed(50);
        drive(1'b1, 1'b1);
        n_checks++; if (state !== 2'd1)    begin n_fail++; $display("FAIL errlast_state got %0d want 1", state); end
        n_checks++; if (tw_addr !== 6'd32) begin n_fail++; $display("FAIL errlast_tw_addr got %0d want 32", tw_addr); end
        tick();
        n_checks++; if (err !== 1'b1)        begin n_fail++; $display("FAIL errlast_err got %b want 1", err); end
        n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL errlast_out_valid got %b want 1", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL errlast_frame_done got %b want 0", frame_done); end
        drive(1'b1, 1'b0);
        n_checks++; if (state !== 2'd1)    begin n_fail++; $display("FAIL errlast_next_state got %0d want 1", state); end
        n_checks++; if (tw_addr !== 6'd48) begin n_fail++; $display("FAIL errlast_next_tw_addr got %0d want 48", tw_addr); end
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL errlast_sticky got %b want 1", err); end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_err_drain();
        do_reset();
        feed(127);
        drive(1'b1, 1'b1);
        tick();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL errdrain_pre_err got %b want 0", err); end
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0);
            n_checks++; if (state !== 2'd3)         begin n_fail++; $display("FAIL errdrain_state j=%0d got %0d want 3", j, state); end
            n_checks++; if (tw_addr !== 6'(j * 16)) begin n_fail++; $display("FAIL errdrain_tw_addr j=%0d got %0d want %0d", j, tw_addr, j * 16); end
            tick();
            n_checks++; if (err !== 1'b1)           begin n_fail++; $display("FAIL errdrain_err j=%0d got %b want 1", j, err); end
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0);
            n_checks++; if (state !== ((k < 4) ? 2'd0 : 2'd2)) begin n_fail++; $display("FAIL errdrain_refill k=%0d got %0d want %0d", k, state, (k < 4) ? 0 : 2); end
            tick();
        end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL errdrain_sticky got %b want 1", err); end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        feed(127);
        drive(1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        n_checks++; if (state !== 2'd3)    begin n_fail++; $display("FAIL areset_pre_state got %0d want 3", state); end
        n_checks++; if (tw_addr !== 6'd16) begin n_fail++; $display("FAIL areset_pre_tw_addr got %0d want 16", tw_addr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL areset_state got %0d want 0", state); end
        n_checks++; if (tw_addr !== 6'd0)    begin n_fail++; $display("FAIL areset_tw_addr got %0d want 0", tw_addr); end
        n_checks++; if (tw_en !== 1'b0)      begin n_fail++; $display("FAIL areset_tw_en got %b want 0", tw_en); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL areset_out_valid got %b want 0", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL areset_frame_done got %b want 0", frame_done); end
        n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL areset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL areset_next_state got %0d want 0", state); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_next_out_valid got %b want 0", out_valid); end
        drive(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_pass();
        test_stall();
        test_wrap();
        test_drain();
        test_err_last();
        test_err_drain();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
